// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Purpose  : Scan controller for a 4-digit seven-segment display plus 8 LEDs.
//            Selects one of four 16-bit debug sources with {choose_2,choose_1}.
//            Takes a snapshot of that source once per frame, so digits never
//            tear. Time-multiplexes the digits, and blanks all digits at the
//            start of each slot to suppress ghosting.
// Ports    : sys_clk     - system clock, rising edge
//            reset       - asynchronous reset, active-high
//            choose_1/2  - source select bits 0/1
//            src0..src3  - 16-bit debug sources
//            freeze      - holds the snapshot across frame boundaries
//            LED         - low byte of the current snapshot
//            bcd_enable  - digit anodes, active-low, bit i = digit i
//            bcd_signal  - segments {g,f,e,d,c,b,a}, active-low
//            frame_done  - one-cycle pulse at each frame boundary
// Options  : `define LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        choose_1,
  input  logic        choose_2,
  input  logic [15:0] src0,
  input  logic [15:0] src1,
  input  logic [15:0] src2,
  input  logic [15:0] src3,
  input  logic        freeze,
  output logic [7:0]  LED,
  output logic [3:0]  bcd_enable,
  output logic [6:0]  bcd_signal,
  output logic        frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] C_SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] C_BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  // Every slot opens with the blanking gap unless blanking is disabled.
  localparam state_t C_SLOT_START = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

  state_t        state_q, state_d;
  logic [CW-1:0] counter_q, counter_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   snapshot_q, snapshot_d;
  logic          frame_done_q, frame_done_d;
  logic [3:0]    bcd_enable_q, bcd_enable_d;
  logic [6:0]    bcd_signal_q, bcd_signal_d;

  logic [15:0]   w_src_sel;
  logic [3:0]    w_nibble;
  logic          w_digit_on;
  logic          w_slot_end;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    case ({choose_2, choose_1})
      2'b00:   w_src_sel = src0;
      2'b01:   w_src_sel = src1;
      2'b10:   w_src_sel = src2;
      default: w_src_sel = src3;
    endcase
  end

  assign w_slot_end = (counter_q == C_SLOT_LAST);

  // Next-state logic: slot counter, digit index and snapshot reloads.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    digit_d      = digit_q;
    snapshot_d   = snapshot_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        // The first frame always loads, regardless of freeze.
        snapshot_d = w_src_sel;
        counter_d  = '0;
        digit_d    = 2'd0;
        state_d    = C_SLOT_START;
      end
      ST_BLANK, ST_DRIVE: begin
        if (w_slot_end) begin
          counter_d = '0;
          digit_d   = digit_q + 2'd1;
          state_d   = C_SLOT_START;
          if (digit_q == 2'd3) begin
            frame_done_d = 1'b1;
            if (!freeze) begin
              snapshot_d = w_src_sel;
            end
          end
        end else begin
          counter_d = counter_q + CW'(1);
          if ((state_q == ST_BLANK) && (counter_q == C_BLANK_LAST)) begin
            state_d = ST_DRIVE;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Display outputs are computed from the next state so that the registered
  // outputs line up cycle-for-cycle with the state register.
  always_comb begin
    case (digit_d)
      2'd0:    w_nibble = snapshot_d[3:0];
      2'd1:    w_nibble = snapshot_d[7:4];
      2'd2:    w_nibble = snapshot_d[11:8];
      default: w_nibble = snapshot_d[15:12];
    endcase

    w_digit_on = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is lit only if it or some higher nibble is nonzero; digit 0
    // is always lit so a zero snapshot still shows "0".
    case (digit_d)
      2'd1:    w_digit_on = |snapshot_d[15:4];
      2'd2:    w_digit_on = |snapshot_d[15:8];
      2'd3:    w_digit_on = |snapshot_d[15:12];
      default: w_digit_on = 1'b1;
    endcase
`else
    w_digit_on = 1'b1;
`endif

    bcd_enable_d = 4'b1111;
    bcd_signal_d = 7'b1111111;
    if ((state_d == ST_DRIVE) && w_digit_on) begin
      bcd_enable_d = ~(4'b0001 << digit_d);
      bcd_signal_d = hex_to_seg(w_nibble);
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      counter_q    <= '0;
      digit_q      <= 2'd0;
      snapshot_q   <= 16'h0000;
      frame_done_q <= 1'b0;
      bcd_enable_q <= 4'b1111;
      bcd_signal_q <= 7'b1111111;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      digit_q      <= digit_d;
      snapshot_q   <= snapshot_d;
      frame_done_q <= frame_done_d;
      bcd_enable_q <= bcd_enable_d;
      bcd_signal_q <= bcd_signal_d;
    end
  end

  assign LED        = snapshot_q[7:0];
  assign bcd_enable = bcd_enable_q;
  assign bcd_signal = bcd_signal_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_ctrl
// Purpose  : Self-checking bench for display_scan_ctrl (SCAN_DIV=8,
//            BLANK_CYCLES=2). Expected digit slots are queued when a new
//            snapshot source is set up and popped as each slot is scanned.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;

  logic        sys_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        choose_1 = 1'b0;
  logic        choose_2 = 1'b0;
  logic [15:0] src0 = 16'h1234;
  logic [15:0] src1 = 16'h1111;
  logic [15:0] src2 = 16'h2222;
  logic [15:0] src3 = 16'h0000;
  logic        freeze = 1'b0;
  logic [7:0]  LED;
  logic [3:0]  bcd_enable;
  logic [6:0]  bcd_signal;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         dig;
    logic [3:0] en;
    logic [6:0] sig;
    logic [7:0] led;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .choose_1   (choose_1),
    .choose_2   (choose_2),
    .src0       (src0),
    .src1       (src1),
    .src2       (src2),
    .src3       (src3),
    .freeze     (freeze),
    .LED        (LED),
    .bcd_enable (bcd_enable),
    .bcd_signal (bcd_signal),
    .frame_done (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the four digit slots of a frame showing value v.
  task automatic push_frame(input logic [15:0] v, input logic first_fd);
    exp_t e;
    logic [15:0] sh;
    for (int d = 0; d < 4; d++) begin
      sh    = v >> (4 * d);
      e.dig = d;
      e.en  = ~(4'b0001 << d);
      e.sig = seg_of(sh[3:0]);
      e.led = v[7:0];
      e.fd  = (d == 0) ? first_fd : 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && sh == 16'h0000) begin
        e.en  = 4'b1111;
        e.sig = 7'b1111111;
      end
`endif
      sb.push_back(e);
    end
  endtask

  // Pop one slot and check ncyc cycles of it, starting at its first cycle.
  task automatic run_slot(input int ncyc);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_underflow observed=%0d expected=nonzero", sb.size());
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge sys_clk);
      chk($sformatf("enable d%0d c%0d", e.dig, i), 16'(bcd_enable),
          (i < BC) ? 16'h000F : 16'(e.en));
      chk($sformatf("segments d%0d c%0d", e.dig, i), 16'(bcd_signal),
          (i < BC) ? 16'h007F : 16'(e.sig));
      chk($sformatf("led d%0d c%0d", e.dig, i), 16'(LED), 16'(e.led));
      chk($sformatf("frame_done d%0d c%0d", e.dig, i), 16'(frame_done),
          (i == 0) ? 16'(e.fd) : 16'h0000);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_enable",   16'(bcd_enable), 16'h000F);
    chk("rst_segments", 16'(bcd_signal), 16'h007F);
    chk("rst_led",      16'(LED),        16'h0000);
    chk("rst_frame",    16'(frame_done), 16'h0000);

    // Frame 1: src0 = 1234 loaded in INIT
    reset = 1'b0;
    push_frame(16'h1234, 1'b0);
    run_slot(SD);
    run_slot(SD);
    // Switch to src3 during digit 1; current frame must not change
    src3     = 16'hABCD;
    choose_1 = 1'b1;
    choose_2 = 1'b1;
    push_frame(16'hABCD, 1'b1);
    run_slot(SD);
    run_slot(SD);

    // Frame 2: ABCD; go back to src0 (still 1234)
    run_slot(SD);
    run_slot(SD);
    choose_1 = 1'b0;
    choose_2 = 1'b0;
    push_frame(16'h1234, 1'b1);
    run_slot(SD);
    run_slot(SD);

    // Frame 3: 1234; freeze across the next boundary while src0 changes
    run_slot(SD);
    run_slot(SD);
    freeze = 1'b1;
    src0   = 16'hFFFF;
    push_frame(16'h1234, 1'b1);
    run_slot(SD);
    run_slot(SD);

    // Frame 4: held 1234; release freeze so the next boundary loads FFFF
    run_slot(SD);
    run_slot(SD);
    freeze = 1'b0;
    push_frame(16'hFFFF, 1'b1);
    run_slot(SD);
    run_slot(SD);

    // Frame 5: FFFF; asynchronous reset during DRIVE of digit 2
    run_slot(SD);
    run_slot(SD);
    run_slot(BC + 2);
    #2 reset = 1'b1;
    #1;
    chk("async_enable",   16'(bcd_enable), 16'h000F);
    chk("async_segments", 16'(bcd_signal), 16'h007F);
    chk("async_led",      16'(LED),        16'h0000);
    chk("async_frame",    16'(frame_done), 16'h0000);
    sb.delete();
    src0 = 16'h0050;
    @(negedge sys_clk);
    reset = 1'b0;

    // Frame 6 after restart: 0050 (leading-zero behaviour depends on build)
    push_frame(16'h0050, 1'b0);
    run_slot(SD);
    run_slot(SD);
    src0 = 16'h0000;
    push_frame(16'h0000, 1'b1);
    run_slot(SD);
    run_slot(SD);

    // Frame 7: 0000
    run_slot(SD);
    run_slot(SD);
    run_slot(SD);
    run_slot(SD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
